// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline control: stall, flush and redirect sequencing with data-memory freeze and timeout.
// Optional PIPE_PERF_CNT_EN macro adds stall and flush performance counters.
module pipeline_ctrl #(
  parameter int ISTRSIZE    = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                r,
  input  logic                hz_stall,
  input  logic                br_taken,
  input  logic [ISTRSIZE-1:0] br_target,
  input  logic                dmem_req,
  input  logic                dmem_ready,
  input  logic                imem_ready,
  output logic                pc_we,
  output logic                pc_sel,
  output logic [ISTRSIZE-1:0] redirect_pc,
  output logic                ifid_we,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                exmem_we,
  output logic                memwb_bubble,
  output logic                mem_err,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
);

  typedef enum logic [1:0] {RUN, MWAIT, REDIR} state_t;

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  state_t              state;
  state_t              eff_state;
  logic                was_redir;
  logic [ISTRSIZE-1:0] pending;
  logic [WCW-1:0]      wait_cnt;
  logic                mem_freeze;
  logic                redirect;

  // MWAIT behaves like the state it froze out of once the memory completes.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    mem_freeze   = dmem_req & ~dmem_ready;
    eff_state    = state;
    if (state == MWAIT) eff_state = was_redir ? REDIR : RUN;
    redirect     = (eff_state == REDIR) | br_taken;
    redirect_pc  = (eff_state == REDIR) ? pending : br_target;
    pc_we        = 1'b1;
    pc_sel       = 1'b0;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_we     = 1'b1;
    memwb_bubble = 1'b0;
    if (!r) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      exmem_we     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mem_freeze) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (redirect) begin
      pc_sel     = 1'b1;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      pc_we      = imem_ready;
      // Waiting in REDIR: ID already holds a bubble, so EX just takes it.
      idex_flush = imem_ready | (eff_state == RUN);
    end else if (hz_stall) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset; it also discards any pending redirect and wait count.
    if (!r) begin
      state     <= RUN;
      was_redir <= 1'b0;
      pending   <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
    end else if (mem_freeze) begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      if (state != MWAIT) was_redir <= (state == REDIR);
      state <= MWAIT;
      if (wait_cnt != WCW'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WCW'(1);
      if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) mem_err <= 1'b1;
    end else begin
      wait_cnt  <= '0;
      was_redir <= 1'b0;
      if (redirect && !imem_ready) begin
        state <= REDIR;
        if (eff_state == RUN) pending <= br_target;
      end else begin
        state <= RUN;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic        redir_flush;

  assign redir_flush = r & ~mem_freeze & redirect & idex_flush;

  always_ff @(posedge clk) begin
    if (!r) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we)      stall_q <= stall_q + 32'd1;
      if (redir_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: stalls, redirects, freezes, timeout and reset.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        r;
  logic        hz_stall, br_taken, dmem_req, dmem_ready, imem_ready;
  logic [31:0] br_target;
  logic        pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_bubble;
  logic [31:0] redirect_pc;
  logic        mem_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0]  ctl;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;
  logic        exp_err   = 1'b0;

  // {pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_bubble}
  localparam logic [6:0] C_RST  = 7'b0001101;
  localparam logic [6:0] C_NORM = 7'b1010010;
  localparam logic [6:0] C_STL  = 7'b0000110;
  localparam logic [6:0] C_RDR  = 7'b1101110;
  localparam logic [6:0] C_PEND = 7'b0101110;
  localparam logic [6:0] C_WAIT = 7'b0101010;
  localparam logic [6:0] C_IMEM = 7'b0001010;
  localparam logic [6:0] C_FRZ  = 7'b0000001;

  pipeline_ctrl #(.ISTRSIZE(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .r(r), .hz_stall(hz_stall), .br_taken(br_taken), .br_target(br_target),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .redirect_pc(redirect_pc), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_we(exmem_we),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_bubble};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive after the edge, check combinational and registered outputs mid-cycle.
  task automatic step(input string tag, input logic rr, input logic hz, input logic br,
                      input logic [31:0] tgt, input logic dreq, input logic drdy,
                      input logic irdy, input logic [6:0] exp_ctl, input logic [31:0] exp_pc);
    @(posedge clk); #1;
    r = rr; hz_stall = hz; br_taken = br; br_target = tgt;
    dmem_req = dreq; dmem_ready = drdy; imem_ready = irdy;
    #3;
    check({tag, ".ctl"}, {25'd0, ctl}, {25'd0, exp_ctl});
    if (exp_ctl[5]) check({tag, ".pc"}, redirect_pc, exp_pc);
    check({tag, ".err"}, {31'd0, mem_err}, {31'd0, exp_err});
`ifdef PIPE_PERF_CNT_EN
    check({tag, ".scnt"}, stall_cnt, exp_stall);
    check({tag, ".fcnt"}, flush_cnt, exp_flush);
`else
    check({tag, ".scnt"}, stall_cnt, 32'd0);
    check({tag, ".fcnt"}, flush_cnt, 32'd0);
`endif
    if (!rr) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!exp_ctl[6]) exp_stall++;
      if (exp_ctl[5] && exp_ctl[2]) exp_flush++;
    end
  endtask

  initial begin
    r = 1'b0; hz_stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    dmem_req = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;
    @(posedge clk);
    step("rst",    0, 1, 1, 32'h100, 1, 0, 1, C_RST, 0);
    step("norm0",  1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    step("hz1",    1, 1, 0, 32'h0,   0, 0, 1, C_STL, 0);
    step("norm1",  1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    step("br100",  1, 0, 1, 32'h100, 0, 0, 1, C_RDR, 32'h100);
    step("norm2",  1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    step("hz2",    1, 1, 0, 32'h0,   0, 0, 1, C_STL, 0);
    step("perf",   1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    step("imem",   1, 0, 0, 32'h0,   0, 0, 0, C_IMEM, 0);
    step("hzimem", 1, 1, 0, 32'h0,   0, 0, 0, C_STL, 0);
    step("br200",  1, 0, 1, 32'h200, 0, 0, 0, C_PEND, 32'h200);
    step("redir1", 1, 0, 1, 32'h300, 0, 0, 0, C_WAIT, 32'h200);
    step("redir2", 1, 1, 0, 32'h999, 0, 0, 0, C_WAIT, 32'h200);
    step("ld200",  1, 0, 0, 32'h999, 0, 0, 1, C_RDR, 32'h200);
    step("norm3",  1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    for (int i = 0; i < 4; i++)
      step($sformatf("frzbr%0d", i), 1, 1, 1, 32'h400, 1, 0, 1, C_FRZ, 0);
    step("ld400",  1, 0, 1, 32'h400, 1, 1, 1, C_RDR, 32'h400);
    step("norm4",  1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    step("br500",  1, 0, 1, 32'h500, 0, 0, 0, C_PEND, 32'h500);
    step("frzrd",  1, 0, 1, 32'h600, 1, 0, 1, C_FRZ, 0);
    step("ld500",  1, 0, 1, 32'h600, 1, 1, 1, C_RDR, 32'h500);
    step("norm5",  1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    // Wait counter must clear between separate freezes.
    for (int i = 0; i < 15; i++)
      step($sformatf("frza%0d", i), 1, 0, 0, 32'h0, 1, 0, 1, C_FRZ, 0);
    step("gap",    1, 0, 0, 32'h0,   1, 1, 1, C_NORM, 0);
    for (int i = 0; i < 15; i++)
      step($sformatf("frzb%0d", i), 1, 0, 0, 32'h0, 1, 0, 1, C_FRZ, 0);
    step("norm6",  1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    // Sixteen consecutive frozen cycles raise the sticky error.
    for (int i = 0; i < 16; i++)
      step($sformatf("frzt%0d", i), 1, 0, 0, 32'h0, 1, 0, 1, C_FRZ, 0);
    exp_err = 1'b1;
    step("errset", 1, 0, 0, 32'h0,   1, 1, 1, C_NORM, 0);
    step("errhld", 1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    step("errrst", 0, 0, 0, 32'h0,   0, 0, 1, C_RST, 0);
    exp_err = 1'b0;
    step("errclr", 1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    // Reset inside REDIR and inside MWAIT drops the pending redirect and wait count.
    step("br700",  1, 0, 1, 32'h700, 0, 0, 0, C_PEND, 32'h700);
    step("rstrd",  0, 0, 1, 32'h700, 0, 0, 0, C_RST, 0);
    step("postrd", 1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("frzc%0d", i), 1, 0, 0, 32'h0, 1, 0, 1, C_FRZ, 0);
    step("rstmw",  0, 0, 0, 32'h0,   1, 0, 1, C_RST, 0);
    for (int i = 0; i < 15; i++)
      step($sformatf("frzd%0d", i), 1, 0, 0, 32'h0, 1, 0, 1, C_FRZ, 0);
    step("postmw", 1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    step("final",  1, 0, 0, 32'h0,   0, 0, 1, C_NORM, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter ISTRSIZE, default 32, instruction/PC width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, maximum data-memory wait cycles before error.
REQ-003 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge
- r  in  1  reset, synchronous, active-low
- hz_stall  in  1  load-use stall request from hazard unit
- br_taken  in  1  EX-stage branch/jump redirect
- br_target  in  ISTRSIZE  redirect PC
- dmem_req  in  1  MEM stage has data-memory access
- dmem_ready  in  1  data memory completes access this cycle
- imem_ready  in  1  fetch accepts PC / returns instruction this cycle
- pc_we  out  1  PC register write enable
- pc_sel  out  1  1 = PC loads redirect_pc, 0 = sequential
- redirect_pc  out  ISTRSIZE  PC to load when pc_sel=1
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID bubble insert
- idex_flush  out  1  ID/EX bubble insert
- exmem_we  out  1  EX/MEM write enable
- memwb_bubble  out  1  MEM/WB bubble insert
- mem_err  out  1  sticky data-memory timeout flag
- stall_cnt  out  32  stall-cycle count
- flush_cnt  out  32  flush-event count

Function
REQ-004 SHALL implement FSM states RUN, MWAIT, REDIR; encoding free.
REQ-005 SHALL define mem_freeze = dmem_req & ~dmem_ready, evaluated in any state.
REQ-006 SHALL give priority mem_freeze > redirect (br_taken or REDIR) > hz_stall > ~imem_ready > normal.
REQ-007 mem_freeze: pc_we=0, ifid_we=0, idex_flush=0, exmem_we=0, memwb_bubble=1; br_taken/hz_stall ignored that cycle.
REQ-008 Redirect, no freeze, imem_ready=1: pc_we=1, pc_sel=1, ifid_flush=1, idex_flush=1, exmem_we=1; next state RUN.
REQ-009 br_taken in RUN with imem_ready=0, no freeze: latch br_target into pending register, go to REDIR; pc_we=0, ifid_flush=1, idex_flush=1.
REQ-010 In REDIR: redirect_pc = pending register; br_taken ignored; pc_we=0, ifid_flush=1 until imem_ready=1, then REQ-008 behaviour and return to RUN.
REQ-011 redirect_pc SHALL equal br_target in RUN and pending register in REDIR.
REQ-012 hz_stall, no freeze/redirect: pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1.
REQ-013 imem_ready=0 only: pc_we=0, ifid_flush=1, remaining stages advance.
REQ-014 Normal: pc_we=1, pc_sel=0, ifid_we=1, exmem_we=1, all flush/bubble 0.
REQ-015 RUN->MWAIT on mem_freeze; MWAIT->RUN on cycle with dmem_ready=1 (that cycle not frozen); pending redirect in REDIR SHALL be preserved across freeze by returning to REDIR.
REQ-016 SHALL count consecutive MWAIT cycles, saturating at MEM_TIMEOUT; on reaching MEM_TIMEOUT set mem_err=1 and hold until reset; counter clears on leaving MWAIT.
REQ-017 ifid_flush and ifid_we SHALL never both be 1; when flush, ifid_we=0.

Reset
REQ-018 While r=0 at clock edge: state=RUN, pending=0, wait counter=0, mem_err=0, perf counters=0.
REQ-019 While r=0: pc_we=0, ifid_we=0, exmem_we=0, ifid_flush=1, idex_flush=1, memwb_bubble=1, pc_sel=0.
REQ-020 Reset mid-MWAIT or mid-REDIR SHALL discard pending redirect and wait count.

Configuration
REQ-021 Macro PIPE_PERF_CNT_EN defined: stall_cnt increments each cycle with pc_we=0 outside reset; flush_cnt increments each cycle with idex_flush=1 from a redirect; both wrap at 2^32.
REQ-022 Macro undefined: stall_cnt and flush_cnt SHALL be constant 0, no counter registers.

Verification
REQ-023 hz_stall=1 one cycle -> pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1; next cycle normal.
REQ-024 br_taken=1, br_target=0x00000100, imem_ready=1 -> pc_we=1, pc_sel=1, redirect_pc=0x100, ifid_flush=idex_flush=1.
REQ-025 br_taken=1, target 0x200, imem_ready=0 three cycles -> REDIR, pc_we=0 for 3 cycles; imem_ready=1 -> redirect_pc=0x200 loaded.
REQ-026 dmem_req=1, dmem_ready=0 for 4 cycles with br_taken=1 -> full freeze 4 cycles, memwb_bubble=1; ready cycle performs redirect.
REQ-027 dmem_ready held 0 for 16 cycles (MEM_TIMEOUT=16) -> mem_err=1, stays 1 after ready until r=0.
REQ-028 With PIPE_PERF_CNT_EN: 2 load-use stalls + 1 redirect -> stall_cnt=2, flush_cnt=1; without -> both 0.
